cdb_result_queue: RTL

//   Per-execution-unit result buffer sitting directly upstream of cdb_arbiter.

---
 rtl/core_pkg.sv | 20 ++
 rtl/rob_age_cmp.sv | 21 ++
 rtl/cdb_result_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core-wide widths, the CDB result record and the ROB age helper.
package core_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned LOG2_PREGS = 6;
  localparam int unsigned LOG2_ROB   = 6;

  typedef struct packed {
    logic [LOG2_PREGS-1:0] tag;
    logic [XLEN-1:0]       value;
    logic [LOG2_ROB-1:0]   rob_tag;
  } cdb_result_t;

  // Distance of a ROB tag from the current oldest entry; wraps mod 2^LOG2_ROB.
  function automatic logic [LOG2_ROB-1:0] rob_age(input logic [LOG2_ROB-1:0] tag,
                                                  input logic [LOG2_ROB-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/rob_age_cmp.sv
// Combinational "is tag younger than the flush reference" compare, relative to rob_head.
module rob_age_cmp #(
  parameter int unsigned ROB_W = 6
) (
  input  logic [ROB_W-1:0] tag_i,
  input  logic [ROB_W-1:0] flush_tag_i,
  input  logic [ROB_W-1:0] head_i,
  output logic             younger_o
);

  logic [ROB_W-1:0] tag_age;
  logic [ROB_W-1:0] ref_age;

  // Ages wrap naturally in ROB_W-bit arithmetic; equal age (the branch itself) is not younger.
  always_comb begin
    tag_age   = tag_i - head_i;
    ref_age   = flush_tag_i - head_i;
    younger_o = (tag_age > ref_age);
  end

endmodule

// File: rtl/cdb_result_queue.sv
// Per-EU result buffer in front of the CDB arbiter with selective and total squash.
module cdb_result_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned XLEN   = core_pkg::XLEN,
  parameter int unsigned PHYS_W = core_pkg::LOG2_PREGS,
  parameter int unsigned ROB_W  = core_pkg::LOG2_ROB
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PHYS_W-1:0]        in_tag,
  input  logic [XLEN-1:0]          in_value,
  input  logic [ROB_W-1:0]         in_rob_tag,
  output logic                     out_valid,
  output logic [PHYS_W-1:0]        out_tag,
  output logic [XLEN-1:0]          out_value,
  output logic [ROB_W-1:0]         out_rob_tag,
  input  logic                     out_grant,
  input  logic                     flush_all,
  input  logic                     flush_valid,
  input  logic [ROB_W-1:0]         flush_rob_tag,
  input  logic [ROB_W-1:0]         rob_head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]        wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0]   live_q, live_d;
  logic [PHYS_W-1:0]  tag_q   [DEPTH];
  logic [PHYS_W-1:0]  tag_d   [DEPTH];
  logic [XLEN-1:0]    value_q [DEPTH];
  logic [XLEN-1:0]    value_d [DEPTH];
  logic [ROB_W-1:0]   rob_q   [DEPTH];
  logic [ROB_W-1:0]   rob_d   [DEPTH];

  logic [AW-1:0]      wr_idx, rd_idx;
  logic               empty, full, push, pop;
  logic [DEPTH-1:0]   ent_young;
  logic               in_young, head_young;

  assign wr_idx = wr_q[AW-1:0];
  assign rd_idx = rd_q[AW-1:0];
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);
  assign count  = wr_q - rd_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent_cmp
    rob_age_cmp #(.ROB_W(ROB_W)) u_ent_cmp (
      .tag_i       (rob_q[i]),
      .flush_tag_i (flush_rob_tag),
      .head_i      (rob_head),
      .younger_o   (ent_young[i])
    );
  end

  rob_age_cmp #(.ROB_W(ROB_W)) u_in_cmp (
    .tag_i       (in_rob_tag),
    .flush_tag_i (flush_rob_tag),
    .head_i      (rob_head),
    .younger_o   (in_young)
  );

  rob_age_cmp #(.ROB_W(ROB_W)) u_head_cmp (
    .tag_i       (rob_q[rd_idx]),
    .flush_tag_i (flush_rob_tag),
    .head_i      (rob_head),
    .younger_o   (head_young)
  );

  // Handshake and head presentation; squash masking is combinational so no killed result escapes.
  always_comb begin
    in_ready    = !full && !reset;
    out_valid   = !empty && live_q[rd_idx] && !flush_all && !(flush_valid && head_young);
    out_tag     = tag_q[rd_idx];
    out_value   = value_q[rd_idx];
    out_rob_tag = rob_q[rd_idx];
    // Dead heads drain one per cycle without ever being offered.
    pop         = !flush_all && ((out_valid && out_grant) || (!empty && !live_q[rd_idx]));
    // A wrong-path incoming result is simply not written.
    push        = in_valid && in_ready && !flush_all && !(flush_valid && in_young);
  end

  // Next-state for pointers, live bits and storage.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    live_d  = live_q;
    tag_d   = tag_q;
    value_d = value_q;
    rob_d   = rob_q;
    if (flush_all) begin
      wr_d   = '0;
      rd_d   = '0;
      live_d = '0;
    end else begin
      if (flush_valid) live_d = live_q & ~ent_young;
      if (pop) begin
        live_d[rd_idx] = 1'b0;
        rd_d           = rd_q + 1'b1;
      end
      // Write slot never aliases a live slot: push needs !full, pop needs !empty.
      if (push) begin
        tag_d[wr_idx]   = in_tag;
        value_d[wr_idx] = in_value;
        rob_d[wr_idx]   = in_rob_tag;
        live_d[wr_idx]  = 1'b1;
        wr_d            = wr_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset; storage cleared so out_* read zero after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      live_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]   <= '0;
        value_q[i] <= '0;
        rob_q[i]   <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      live_q  <= live_d;
      tag_q   <= tag_d;
      value_q <= value_d;
      rob_q   <= rob_d;
    end
  end

endmodule
